// File: rtl/inst_fetch.sv
// inst_fetch: rv32i fetch stage - PC register, ROM address drive and a small output FIFO.
// Optional macro FETCH_MISALIGN_CHK_EN flags the first entry fetched after a misaligned redirect.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_pc,
  output logic              out_misalign
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      pc;
  logic [31:0]      mem_pc   [DEPTH];
  logic [31:0]      mem_inst [DEPTH];
  logic             mem_mis  [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             pend;
  logic             pop;
  logic             fetch;
  logic             mis_target;

`ifdef FETCH_MISALIGN_CHK_EN
  assign mis_target = |redirect_pc[1:0];
`else
  // Low target bits are dropped; pending-misalign therefore stays 0.
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign mis_target      = 1'b0;
`endif

  assign rom_addr     = pc[ADDR_W-1:0];
  assign out_valid    = (count != '0);
  assign out_pc       = mem_pc[rd_ptr];
  assign out_inst     = mem_inst[rd_ptr];
  assign out_misalign = mem_mis[rd_ptr];

  always_comb begin
    pop   = out_valid && out_ready;
    fetch = !redirect_valid && ((count < CNT_W'(DEPTH)) || pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      pend     <= 1'b0;
      mem_pc   <= '{default: '0};
      mem_inst <= '{default: '0};
      mem_mis  <= '{default: 1'b0};
    end else if (redirect_valid) begin
      // A same-cycle pop is already owned by decode, so a plain flush is enough.
      pc     <= {redirect_pc[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pend   <= mis_target;
    end else begin
      if (fetch) begin
        mem_pc[wr_ptr]   <= pc;
        mem_inst[wr_ptr] <= rom_inst;
        mem_mis[wr_ptr]  <= pend;
        wr_ptr           <= wr_ptr + PTR_W'(1);
        pc               <= pc + 32'd4;
        pend             <= 1'b0;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(fetch) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: two instances (default, and wrapping RESET_PC with DEPTH 4)
// checked against a shift-array model of the fetch buffer.
module tb_inst_fetch;

`ifdef FETCH_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic [11:0] rom_addr0, rom_addr1;
  logic [31:0] rom_inst0, rom_inst1;
  logic        out_valid0, out_valid1;
  logic [31:0] out_inst0, out_inst1;
  logic [31:0] out_pc0, out_pc1;
  logic        out_misalign0, out_misalign1;

  int checks;
  int failures;

  function automatic logic [31:0] rom_word(input logic [11:0] a);
    return 32'h1000_0000 + 32'(a >> 2);
  endfunction

  assign rom_inst0 = rom_word(rom_addr0);
  assign rom_inst1 = rom_word(rom_addr1);

  inst_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(12), .DEPTH(2)) dut0 (
    .clk(clk), .reset(reset), .rom_addr(rom_addr0), .rom_inst(rom_inst0),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid0), .out_ready(out_ready), .out_inst(out_inst0),
    .out_pc(out_pc0), .out_misalign(out_misalign0)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .ADDR_W(12), .DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .rom_addr(rom_addr1), .rom_inst(rom_inst1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid1), .out_ready(out_ready), .out_inst(out_inst1),
    .out_pc(out_pc1), .out_misalign(out_misalign1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: entry 0 of each array is the head; entries shift down on a pop.
  logic [31:0] m_pc   [2];
  logic        m_pend [2];
  int          m_cnt  [2];
  logic [31:0] q_pc   [2][4];
  logic [31:0] q_inst [2][4];
  logic        q_mis  [2][4];

  function automatic logic [31:0] reset_pc_of(input int k);
    return (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
  endfunction

  function automatic int depth_of(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int k, input logic rst, input logic rv,
                            input logic [31:0] rp, input logic rdy);
    logic pop, fetch;
    if (rst) begin
      m_pc[k]   = reset_pc_of(k);
      m_cnt[k]  = 0;
      m_pend[k] = 1'b0;
      return;
    end
    pop   = (m_cnt[k] > 0) && rdy;
    fetch = !rv && ((m_cnt[k] < depth_of(k)) || pop);
    if (pop) begin
      for (int j = 0; j < 3; j++) begin
        q_pc[k][j]   = q_pc[k][j+1];
        q_inst[k][j] = q_inst[k][j+1];
        q_mis[k][j]  = q_mis[k][j+1];
      end
      m_cnt[k]--;
    end
    if (rv) begin
      m_cnt[k]  = 0;
      m_pc[k]   = {rp[31:2], 2'b00};
      m_pend[k] = MIS_EN && (rp[1:0] != 2'b00);
    end else if (fetch) begin
      q_pc[k][m_cnt[k]]   = m_pc[k];
      q_inst[k][m_cnt[k]] = rom_word(m_pc[k][11:0]);
      q_mis[k][m_cnt[k]]  = m_pend[k];
      m_cnt[k]++;
      m_pend[k] = 1'b0;
      m_pc[k]   = m_pc[k] + 32'd4;
    end
  endtask

  task automatic compare(input int k, input logic [11:0] ra, input logic ov,
                         input logic [31:0] op, input logic [31:0] oi, input logic om);
    check($sformatf("rom_addr%0d", k), 32'(ra), 32'(m_pc[k][11:0]));
    check($sformatf("out_valid%0d", k), 32'(ov), 32'(m_cnt[k] != 0));
    if (m_cnt[k] != 0) begin
      check($sformatf("out_pc%0d", k), op, q_pc[k][0]);
      check($sformatf("out_inst%0d", k), oi, q_inst[k][0]);
      check($sformatf("out_misalign%0d", k), 32'(om), 32'(q_mis[k][0]));
    end
  endtask

  task automatic step(input logic rst, input logic rv, input logic [31:0] rp, input logic rdy);
    @(negedge clk);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = rdy;
    #1;
    compare(0, rom_addr0, out_valid0, out_pc0, out_inst0, out_misalign0);
    compare(1, rom_addr1, out_valid1, out_pc1, out_inst1, out_misalign1);
    model_step(0, rst, rv, rp, rdy);
    model_step(1, rst, rv, rp, rdy);
  endtask

  initial begin
    logic        r_rst, r_rv, r_rdy;
    logic [31:0] r_rp;
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0123;
    out_ready      = 1'b1;
    repeat (2) @(posedge clk);
    model_step(0, 1'b1, 1'b0, '0, 1'b0);
    model_step(1, 1'b1, 1'b0, '0, 1'b0);

    // Reset state, including cleared entries and reset overriding redirect.
    @(negedge clk);
    #1;
    check("rst_valid0", 32'(out_valid0), 32'd0);
    check("rst_pc0", out_pc0, 32'd0);
    check("rst_inst0", out_inst0, 32'd0);
    check("rst_mis0", 32'(out_misalign0), 32'd0);
    check("rst_rom_addr1", 32'(rom_addr1), 32'h0000_0FF8);
    check("rst_inst1", out_inst1, 32'd0);

    // Backpressure from reset, then drain.
    repeat (6) step(1'b0, 1'b0, '0, 1'b0);
    repeat (6) step(1'b0, 1'b0, '0, 1'b1);
    // Redirect while entries are buffered.
    repeat (3) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0040, 1'b0);
    repeat (4) step(1'b0, 1'b0, '0, 1'b1);
    // Redirect together with a pop.
    repeat (2) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0080, 1'b1);
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
    // Misaligned redirect, then PC wrap.
    step(1'b0, 1'b1, 32'h0000_0042, 1'b1);
    repeat (4) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 32'hFFFF_FFF6, 1'b0);
    repeat (6) step(1'b0, 1'b0, '0, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(0, 63) == 0);
      r_rv  = ($urandom_range(0, 7) == 0);
      r_rp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                          : 32'($urandom_range(0, 1023));
      r_rdy = ($urandom_range(0, 9) < 7);
      step(r_rst, r_rv, r_rp, r_rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
